ret_addr_stack: RTL and testbench
=================================

# ret_addr_stack

Hardware return-address stack in the fetch stage, directly upstream of the program-counter load-select mux. On a call it captures the 14-bit return address. On a return it pops, and the new top of stack drives the mux's `ret_addr` input. It is a circular LIFO: overflow silently discards the oldest entry.

## Interface

Parameters:
- `ADDR_WIDTH`, default 14: width of stored program-counter values.
- `DEPTH`, default 8: number of entries. Must be a power of two, 2..64.

Ports:
- `clock`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `push`, input, 1: call retiring this cycle; store `push_addr`.
- `push_addr`, input, ADDR_WIDTH: return address, i.e. call PC + 1.
- `pop`, input, 1: return retiring this cycle; discard the top entry.
- `ret_addr`, output, ADDR_WIDTH: current top of stack; 0 when empty.
- `empty`, output, 1: count == 0.
- `full`, output, 1: count == DEPTH.
- `overflow_err`, output, 1: sticky; present only with `RET_STACK_ERR_FLAGS_EN`.
- `underflow_err`, output, 1: sticky; present only with `RET_STACK_ERR_FLAGS_EN`.
- `err_clear`, input, 1: clears the sticky flags; present only with `RET_STACK_ERR_FLAGS_EN`.

## Operation

- State:
  - `tos` pointer, clog2(DEPTH) bits, indexes the top entry.
  - `count`, clog2(DEPTH)+1 bits, range 0..DEPTH.
  - Storage array of DEPTH × ADDR_WIDTH.
- Push only:
  - `tos <= tos+1` (mod DEPTH), then `mem[tos+1] <= push_addr`.
  - `count <= min(count+1, DEPTH)`.
  - When full, the oldest entry is overwritten; `count` stays DEPTH.
- Pop only, count > 0: `tos <= tos-1` (mod DEPTH), `count <= count-1`. Memory is untouched.
- Pop only, count == 0: underflow. No state change; `ret_addr` stays 0.
- Push and pop together, count > 0: replace. `mem[tos] <= push_addr`; `tos` and `count` unchanged. This is a return immediately followed by a call.
- Push and pop together, count == 0: treated as a plain push. No underflow.
- Neither asserted: hold.
- `ret_addr` = `mem[tos]` when count > 0, else 0. It is a function of registered state only; there is no combinational path from `push`/`pop`/`push_addr` to any output.
- `empty` and `full` are decoded from `count`.

## Timing

- Reset (asynchronous, immediate): `tos`=0, `count`=0, `ret_addr`=0, `empty`=1, `full`=0, error flags=0. Memory contents are not reset; they are unobservable while count == 0.
- Latency: a push at edge N makes `push_addr` visible on `ret_addr` after edge N (cycle N+1). A pop at edge N exposes the previous entry in cycle N+1.
- No handshake. `push`/`pop` are single-cycle qualifiers, one operation per cycle; the caller guarantees they are sampled only for retiring instructions.
- Reset asserted mid-operation overrides any same-cycle push/pop; the stack is empty at the first edge after release.
- Wrap-around: `tos` DEPTH-1 + push → 0; `tos` 0 + pop → DEPTH-1 (count permitting).

## Configuration

- `RET_STACK_ERR_FLAGS_EN` defined:
  - `overflow_err` sets on any push-only while full.
  - `underflow_err` sets on pop-only while empty.
  - Both hold until `err_clear`=1 or reset.
  - A set event coinciding with `err_clear` leaves the flag set (set wins).
- Not defined: ports and flag logic are absent; overflow and underflow behave identically but unflagged.

## Structure

- Shared fetch-stage package/header: `PC_WIDTH` = 14 and `RET_STACK_DEPTH` = 8 as the default sources for the parameters.
- One sub-module: `ret_addr_stack_mem`, a DEPTH × ADDR_WIDTH register array with one synchronous write port and one asynchronous read port.
- The pointer/count control and error flags live in the top module.

## Test plan

- Reset, then idle → `empty`=1, `ret_addr`=0, `full`=0.
- Push 0x0101, 0x0202, 0x0303 on consecutive cycles, then pop each cycle → `ret_addr` shows 0x0303, 0x0202, 0x0101, 0; `empty`=1 after the third pop.
- Push 9 values 0x0010..0x0018 with DEPTH=8 → `full`=1, `ret_addr`=0x0018, `overflow_err`=1 (macro on). Eight pops yield 0x0018..0x0011, then `empty`=1.
- Push 0x0AAA, then push+pop with 0x0BBB → `ret_addr`=0x0BBB, count unchanged at 1. Push+pop on an empty stack with 0x0CCC → `ret_addr`=0x0CCC, count=1, `underflow_err`=0.
- Pop on empty → no change, `underflow_err`=1. `err_clear` pulse → 0. `err_clear` coinciding with another underflow → stays 1.
- Assert `reset` asynchronously between edges after 3 pushes → outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/ret_addr_stack_pkg.sv
// Shared fetch-stage definitions for the return-address stack: default widths,
// the per-cycle operation encoding and its decoder.
package ret_addr_stack_pkg;

  localparam int PC_WIDTH        = 14;
  localparam int RET_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_UNDERFLOW
  } stack_op_e;

  // A push+pop on an empty stack has nothing to replace, so it degrades to a push.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic is_empty);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return is_empty ? OP_UNDERFLOW : OP_POP;
      2'b11:   return is_empty ? OP_PUSH : OP_REPLACE;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Call/return interface between fetch control and the return-address stack.
// Error-flag signals exist only when RET_STACK_ERR_FLAGS_EN is defined.
interface ret_addr_stack_if
  import ret_addr_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH
);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  empty;
  logic                  full;

`ifdef RET_STACK_ERR_FLAGS_EN
  logic err_clear;
  logic overflow_err;
  logic underflow_err;

  modport master (output push, pop, push_addr, err_clear,
                  input  ret_addr, empty, full, overflow_err, underflow_err);
  modport slave  (input  push, pop, push_addr, err_clear,
                  output ret_addr, empty, full, overflow_err, underflow_err);
`else
  modport master (output push, pop, push_addr,
                  input  ret_addr, empty, full);
  modport slave  (input  push, pop, push_addr,
                  output ret_addr, empty, full);
`endif

endinterface

// File: rtl/ret_addr_stack_mem.sv
// Return-address storage: DEPTH x ADDR_WIDTH registers, one synchronous write
// port and one asynchronous read port.
module ret_addr_stack_mem #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 8
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0]    rd_data
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; entries are only visible once count covers
  // them, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack (top): pointer/count control and optional sticky
// error flags, enabled by defining RET_STACK_ERR_FLAGS_EN.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = RET_STACK_DEPTH
) (
  input logic             clock,
  input logic             reset,
  ret_addr_stack_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      tos, tos_next, wr_addr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_data;
  logic                  is_empty, is_full;
  stack_op_e             op;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_COUNT);
  assign op       = decode_op(bus.push, bus.pop, is_empty);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    tos_next   = tos;
    count_next = count;
    wr_en      = 1'b0;
    wr_addr    = tos;
    case (op)
      OP_PUSH: begin
        tos_next = tos + 1'b1;
        wr_en    = 1'b1;
        wr_addr  = tos + 1'b1;
        // When full the write lands on the oldest slot and count saturates.
        if (!is_full) count_next = count + 1'b1;
      end
      OP_REPLACE: wr_en = 1'b1;
      OP_POP: begin
        tos_next   = tos - 1'b1;
        count_next = count - 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tos   <= '0;
      count <= '0;
    end else begin
      tos   <= tos_next;
      count <= count_next;
    end
  end

  ret_addr_stack_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.push_addr),
    .rd_addr (tos),
    .rd_data (rd_data)
  );

  assign bus.ret_addr = is_empty ? '0 : rd_data;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;

`ifdef RET_STACK_ERR_FLAGS_EN
  logic overflow_err, underflow_err;

  // A set event outranks a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (op == OP_PUSH && is_full) overflow_err <= 1'b1;
      else if (bus.err_clear)        overflow_err <= 1'b0;
      if (op == OP_UNDERFLOW)        underflow_err <= 1'b1;
      else if (bus.err_clear)        underflow_err <= 1'b0;
    end
  end

  assign bus.overflow_err  = overflow_err;
  assign bus.underflow_err = underflow_err;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack; flag checks are compiled in
// when RET_STACK_ERR_FLAGS_EN is defined.
module tb_ret_addr_stack;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  ret_addr_stack_if #(.ADDR_WIDTH(14)) bus ();

  ret_addr_stack #(.ADDR_WIDTH(14), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic check_top(input string tag, input logic [13:0] ret,
                           input logic emp, input logic ful);
    check({tag, ".ret_addr"}, {2'b00, bus.ret_addr}, {2'b00, ret});
    check({tag, ".empty"},    {15'd0, bus.empty},    {15'd0, emp});
    check({tag, ".full"},     {15'd0, bus.full},     {15'd0, ful});
  endtask

`ifdef RET_STACK_ERR_FLAGS_EN
  task automatic check_flags(input string tag, input logic ovf, input logic udf);
    check({tag, ".overflow_err"},  {15'd0, bus.overflow_err},  {15'd0, ovf});
    check({tag, ".underflow_err"}, {15'd0, bus.underflow_err}, {15'd0, udf});
  endtask
`endif

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [13:0] a);
    bus.push      = p;
    bus.pop       = q;
    bus.push_addr = a;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_addr = '0;
`ifdef RET_STACK_ERR_FLAGS_EN
    bus.err_clear = 1'b0;
`endif

    // Reset and idle
    #2;
    check_top("in_reset", 14'h0000, 1'b1, 1'b0);
    #10 reset = 1'b0;
    step(1'b0, 1'b0, 14'h0);
    check_top("idle", 14'h0000, 1'b1, 1'b0);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("idle", 1'b0, 1'b0);
`endif

    // Basic LIFO order
    step(1'b1, 1'b0, 14'h0101); check_top("push1", 14'h0101, 1'b0, 1'b0);
    step(1'b1, 1'b0, 14'h0202); check_top("push2", 14'h0202, 1'b0, 1'b0);
    step(1'b1, 1'b0, 14'h0303); check_top("push3", 14'h0303, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0);    check_top("pop1",  14'h0202, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0);    check_top("pop2",  14'h0101, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0);    check_top("pop3",  14'h0000, 1'b1, 1'b0);

    // Fill, then overflow with a ninth push (tos also wraps)
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 14'(16 + i));
    check_top("fill8", 14'h0017, 1'b0, 1'b1);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("fill8", 1'b0, 1'b0);
`endif
    step(1'b1, 1'b0, 14'h0018);
    check_top("push9", 14'h0018, 1'b0, 1'b1);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("push9", 1'b1, 1'b0);
`endif
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 14'h0);
      check_top("drain", 14'(24 - k), 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 14'h0);
    check_top("drain_last", 14'h0000, 1'b1, 1'b0);

    // Replace, and push+pop on an empty stack
    step(1'b1, 1'b0, 14'h0AAA); check_top("push_aaa", 14'h0AAA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 14'h0BBB); check_top("replace",  14'h0BBB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0);    check_top("replace_pop", 14'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 14'h0CCC); check_top("pp_empty", 14'h0CCC, 1'b0, 1'b0);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("pp_empty", 1'b1, 1'b0);
`endif
    step(1'b0, 1'b1, 14'h0);    check_top("pp_pop", 14'h0000, 1'b1, 1'b0);

    // Underflow
    step(1'b0, 1'b1, 14'h0);    check_top("underflow", 14'h0000, 1'b1, 1'b0);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("underflow", 1'b1, 1'b1);
    bus.err_clear = 1'b1;
    step(1'b0, 1'b0, 14'h0);
    check_flags("clear", 1'b0, 1'b0);
    step(1'b0, 1'b1, 14'h0);
    check_flags("clear_vs_set", 1'b0, 1'b1);
    bus.err_clear = 1'b0;
    step(1'b0, 1'b0, 14'h0);
    check_flags("held", 1'b0, 1'b1);
`endif

    // Asynchronous reset between edges, with a push pending during reset
    step(1'b1, 1'b0, 14'h0011);
    step(1'b1, 1'b0, 14'h0022);
    step(1'b1, 1'b0, 14'h0033);
    check_top("pre_reset", 14'h0033, 1'b0, 1'b0);
    bus.push_addr = 14'h0777;
    #2 reset = 1'b1;
    #1;
    check_top("async_reset", 14'h0000, 1'b1, 1'b0);
`ifdef RET_STACK_ERR_FLAGS_EN
    check_flags("async_reset", 1'b0, 1'b0);
`endif
    @(posedge clock); #1;
    check_top("reset_vs_push", 14'h0000, 1'b1, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 14'h0);
    check_top("after_reset", 14'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 14'h0123);
    check_top("push_after_reset", 14'h0123, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
